// File: rtl/dot_pkg.sv
// Shared types for the dot_product engine and its front-end loader.
// Holds the loader FSM states, the result-width helper and the packed vector type.
package dot_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } dot_ld_state_e;

  localparam int DOT_N     = 8;
  localparam int DOT_WIDTH = 8;

  // A dot product of N products of two WIDTH-bit values fits in 2*WIDTH+4 bits for N<=16.
  function automatic int res_w(input int width);
    return 2 * width + 4;
  endfunction

  localparam int RES_W = res_w(DOT_WIDTH);

  typedef logic [DOT_N-1:0][DOT_WIDTH-1:0] dot_vec_t;

endpackage

// File: rtl/dot_ref_mac.sv
// Serial signed reference MAC: accumulates one product per enable, and on clr
// latches the running sum into sum while restarting the accumulator at zero.
module dot_ref_mac #(
  parameter int WIDTH = 8,
  parameter int RW    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [RW-1:0]    sum
);

  logic signed [RW-1:0] acc;
  logic signed [RW-1:0] ea;
  logic signed [RW-1:0] eb;

  assign ea = {{(RW-WIDTH){a[WIDTH-1]}}, a};
  assign eb = {{(RW-WIDTH){b[WIDTH-1]}}, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sum <= '0;
    end else if (clr) begin
      sum <= acc;
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ea * eb;
    end
  end

endmodule

// File: rtl/dot_vec_loader.sv
// Streams N signed element pairs into packed vectors, kicks dot_product, and returns
// its result (or a forced zero on timeout). DOT_LOADER_CHECK_EN adds a reference MAC.
module dot_vec_loader
  import dot_pkg::*;
#(
  parameter int N       = 8,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,  // must be >= 1
  localparam int RW     = res_w(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  output logic [N-1:0][WIDTH-1:0]   vec_a,
  output logic [N-1:0][WIDTH-1:0]   vec_b,
  output logic                      vec_start,
  input  logic [RW-1:0]             eng_dot,
  input  logic                      eng_valid,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RW-1:0]             res_data,
  output logic                      res_timeout,
  output logic                      res_mismatch
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // Both ports are valid/ready: a transfer happens at a rising edge where valid and
  // ready are both high; valid does not depend on ready.
  dot_ld_state_e state_q, state_d;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          last_lane;
  logic          capture;
  logic          expire;
  logic          drain;

  assign last_lane = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    vec_start = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    drain     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && last_lane) state_d = ISSUE;
      end
      ISSUE: begin
        vec_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        drain     = res_ready;
        if (res_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      tcnt        <= '0;
      vec_a       <= '0;
      vec_b       <= '0;
      res_data    <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        vec_a[cnt] <= in_a;
        vec_b[cnt] <= in_b;
        cnt        <= last_lane ? '0 : cnt + 1'b1;
      end
      if (vec_start)
        tcnt <= '0;
      else if (state_q == WAIT && !capture && !expire)
        tcnt <= tcnt + 1'b1;
      if (capture) begin
        res_data    <= eng_dot;
        res_timeout <= 1'b0;
      end else if (expire) begin
        res_data    <= '0;
        res_timeout <= 1'b1;
      end else if (drain) begin
        res_timeout <= 1'b0;
      end
    end
  end

`ifdef DOT_LOADER_CHECK_EN
  logic [RW-1:0] ref_sum;
  logic          mismatch_q;

  // The MAC latches its sum in the ISSUE cycle, so it is ready well before any capture.
  dot_ref_mac #(
    .WIDTH (WIDTH),
    .RW    (RW)
  ) u_ref_mac (
    .clk    (clk),
    .rst    (rst),
    .acc_en (accept),
    .clr    (vec_start),
    .a      (in_a),
    .b      (in_b),
    .sum    (ref_sum)
  );

  always_ff @(posedge clk) begin
    if (rst)                   mismatch_q <= 1'b0;
    else if (capture)          mismatch_q <= (eng_dot != ref_sum);
    else if (expire || drain)  mismatch_q <= 1'b0;
  end

  assign res_mismatch = mismatch_q;
`else
  assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_dot_vec_loader.sv
// Directed bench for dot_vec_loader with a 3-cycle behavioural engine and a
// result scoreboard; set DOT_LOADER_CHECK_EN to exercise the mismatch flag.
module tb_dot_vec_loader;
  import dot_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int TO = 16;
  localparam int RW = 2 * W + 4;
`ifdef DOT_LOADER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_a;
  logic [W-1:0]          in_b;
  logic [N-1:0][W-1:0]   vec_a;
  logic [N-1:0][W-1:0]   vec_b;
  logic                  vec_start;
  logic [RW-1:0]         eng_dot;
  logic                  eng_valid;
  logic                  res_valid;
  logic                  res_ready;
  logic [RW-1:0]         res_data;
  logic                  res_timeout;
  logic                  res_mismatch;

  dot_vec_loader #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .vec_a        (vec_a),
    .vec_b        (vec_b),
    .vec_start    (vec_start),
    .eng_dot      (eng_dot),
    .eng_valid    (eng_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_timeout  (res_timeout),
    .res_mismatch (res_mismatch)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural engine: result valid 3 cycles after vec_start
  logic [2:0]    sr;
  logic [RW-1:0] eng_hold;
  logic          silent;
  logic          override;
  logic          late;

  function automatic logic [RW-1:0] model_dot(input logic [N-1:0][W-1:0] va,
                                              input logic [N-1:0][W-1:0] vb);
    int s;
    int pa;
    int pb;
    s = 0;
    for (int k = 0; k < N; k++) begin
      pa = $signed(va[k]);
      pb = $signed(vb[k]);
      s  = s + pa * pb;
    end
    return RW'(s);
  endfunction

  always @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], vec_start};
    if (vec_start) eng_hold <= override ? RW'(37) : model_dot(vec_a, vec_b);
  end

  assign eng_valid = (sr[2] && !silent) || late;
  assign eng_dot   = eng_hold;

  int starts;
  always @(posedge clk) begin
    if (rst)            starts <= 0;
    else if (vec_start) starts <= starts + 1;
  end

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic          exp_to_q[$];
  logic          exp_mm_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: pushes the expected result, then streams one pair per cycle
  task automatic send_vec(input logic [W-1:0] a [N], input logic [W-1:0] b [N],
                          input logic to, input logic ovr);
    int s;
    int pa;
    int pb;
    s = 0;
    for (int i = 0; i < N; i++) begin
      pa = $signed(a[i]);
      pb = $signed(b[i]);
      s  = s + pa * pb;
    end
    if (to) begin
      exp_q.push_back('0);
      exp_to_q.push_back(1'b1);
      exp_mm_q.push_back(1'b0);
    end else begin
      exp_q.push_back(ovr ? RW'(37) : RW'(s));
      exp_to_q.push_back(1'b0);
      exp_mm_q.push_back(CHK && ovr && (s != 37));
    end
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_a     = a[i];
      in_b     = b[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic consume(input string tag);
    logic [RW-1:0] ed;
    logic          et;
    logic          em;
    ed = exp_q.pop_front();
    et = exp_to_q.pop_front();
    em = exp_mm_q.pop_front();
    check({tag, "_res_valid"}, res_valid, 1'b1);
    check({tag, "_res_data"}, res_data, ed);
    check({tag, "_res_timeout"}, res_timeout, et);
    check({tag, "_res_mismatch"}, res_mismatch, em);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_drained"}, res_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_flags_clr"}, {res_timeout, res_mismatch}, 2'b00);
  endtask

  logic [W-1:0] va [N];
  logic [W-1:0] vb [N];
  logic [N-1:0][W-1:0] pk;
  int s0;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    silent = 1'b0; override = 1'b0; late = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_vec_a", vec_a, '0);
    check("rst_vec_b", vec_b, '0);
    check("rst_outs", {vec_start, res_valid, res_timeout, res_mismatch}, 4'b0000);
    check("rst_res_data", res_data, '0);
    check("rst_cnt", dut.cnt, 0);

    // case 1: A=1..8, B=1
    for (int i = 0; i < N; i++) begin va[i] = W'(i + 1); vb[i] = 8'd1; end
    s0 = starts;
    send_vec(va, vb, 1'b0, 1'b0);
    check("c1_vec_start", vec_start, 1'b1);
    check("c1_in_ready_low", in_ready, 1'b0);
    for (int k = 0; k < N; k++) begin
      check("c1_lane_a", vec_a[k], k + 1);
      check("c1_lane_b", vec_b[k], 1);
    end
    @(negedge clk);
    check("c1_start_pulse", vec_start, 1'b0);
    wait_result("c1", 3);
    check("c1_data_36", res_data, 20'd36);
    consume("c1");
    check("c1_one_start", starts - s0, 1);

    // case 2: A=-50, B=49 -> -19600
    for (int i = 0; i < N; i++) begin va[i] = 8'hCE; vb[i] = 8'd49; end
    send_vec(va, vb, 1'b0, 1'b0);
    wait_result("c2", 4);
    check("c2_data_neg", res_data, 20'hFB370);
    consume("c2");

    // case 3: random vector, consumer stalls 5 cycles while pairs are offered
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom_range(0, 255));
      vb[i] = W'($urandom_range(0, 255));
      pk[i] = va[i];
    end
    send_vec(va, vb, 1'b0, 1'b0);
    wait_result("c3", 4);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a = W'($urandom_range(0, 255));
      in_b = W'($urandom_range(0, 255));
      @(negedge clk);
      check("c3_hold_valid", res_valid, 1'b1);
      check("c3_hold_data", res_data, exp_q[0]);
      check("c3_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("c3_no_accept_cnt", dut.cnt, 0);
    check("c3_lanes_stable", vec_a, pk);
    consume("c3");

    // case 4: silent engine -> timeout, late eng_valid in HOLD ignored
    silent = 1'b1;
    for (int i = 0; i < N; i++) begin va[i] = W'(i + 1); vb[i] = 8'd1; end
    send_vec(va, vb, 1'b1, 1'b0);
    wait_result("c4", TO + 1);
    late = 1'b1;
    @(negedge clk);
    late = 1'b0;
    @(negedge clk);
    check("c4_late_data", res_data, '0);
    check("c4_late_timeout", res_timeout, 1'b1);
    consume("c4");
    silent = 1'b0;

    // case 5: reset after 3 accepted pairs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'h55; in_b = 8'h66;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("c5_cnt_before", dut.cnt, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("c5_cnt_cleared", dut.cnt, 0);
    check("c5_lanes_a", vec_a, '0);
    check("c5_lanes_b", vec_b, '0);
    check("c5_in_ready", in_ready, 1'b1);
    for (int i = 0; i < N; i++) begin
      va[i] = W'($urandom_range(0, 255));
      vb[i] = W'($urandom_range(0, 255));
    end
    send_vec(va, vb, 1'b0, 1'b0);
    wait_result("c5", 4);
    consume("c5");
    check("c5_one_start", starts, 1);

    // case 6: engine returns 37 for the case-1 vector
    override = 1'b1;
    for (int i = 0; i < N; i++) begin va[i] = W'(i + 1); vb[i] = 8'd1; end
    send_vec(va, vb, 1'b0, 1'b1);
    wait_result("c6", 4);
    consume("c6");
    override = 1'b0;

    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
